// File: rtl/vera_render_pkg.sv
// vera_render_pkg: shared types for the line render scheduler.
// State encoding, renderer order and default limits.
package vera_render_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L0,
        ST_L1,
        ST_SPR,
        ST_ABORT
    } state_t;

    // Bit positions in the enable snapshot, also the render order.
    localparam int NUM_UNITS = 3;
    localparam int UNIT_L0   = 0;
    localparam int UNIT_L1   = 1;
    localparam int UNIT_SPR  = 2;

    localparam int DEF_TIMEOUT_CYCLES = 800;
    localparam int DEF_CNT_W          = 8;

    // First enabled unit strictly after cur in L0 -> L1 -> SPR order.
    // IDLE/ABORT search from the top; ST_IDLE means nothing is left.
    function automatic state_t next_unit(
        input state_t                 cur,
        input logic [NUM_UNITS-1:0]   en
    );
        state_t nxt;
        nxt = ST_IDLE;
        case (cur)
            ST_L0: begin
                if (en[UNIT_L1])
                    nxt = ST_L1;
                else if (en[UNIT_SPR])
                    nxt = ST_SPR;
            end
            ST_L1: begin
                if (en[UNIT_SPR])
                    nxt = ST_SPR;
            end
            ST_SPR: begin
                nxt = ST_IDLE;
            end
            default: begin
                if (en[UNIT_L0])
                    nxt = ST_L0;
                else if (en[UNIT_L1])
                    nxt = ST_L1;
                else if (en[UNIT_SPR])
                    nxt = ST_SPR;
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear.
// Clear wins over a coincident increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX = '1;

    // Count up to MAX and hold there; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc && (value != MAX))
            value <= value + W'(1);
    end

endmodule

// File: rtl/render_line_scheduler.sv
// render_line_scheduler: runs the enabled line renderers in turn
// for each compositor request, with overrun/watchdog abort.
module render_line_scheduler
    import vera_render_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_render_start,
    input  logic [8:0]       line_idx,
    input  logic             layer0_enabled,
    input  logic             layer1_enabled,
    input  logic             sprites_enabled,
    input  logic             layer0_done,
    input  logic             layer1_done,
    input  logic             sprite_done,
    input  logic             clear_stats,
    output logic             layer0_start,
    output logic             layer1_start,
    output logic             sprite_start,
    output logic             render_abort,
    output logic [8:0]       render_line_idx,
    output logic             lb_wr_bank,
    output logic             busy,
    output logic             line_done,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    state_t                 nxt;
    logic [NUM_UNITS-1:0]   en_in;
    logic [NUM_UNITS-1:0]   en_q;
    logic [WD_W-1:0]        wdog;
    logic                   wd_expire;
    logic                   advance;
    logic                   overrun_inc;
    logic                   timeout_inc;

    assign en_in = {sprites_enabled, layer1_enabled, layer0_enabled};

    assign wd_expire   = busy && (wdog == WD_LAST);
    assign overrun_inc = line_render_start && busy;
    assign timeout_inc = wd_expire && !line_render_start;

    // Decide when the current step is finished; a done in the
    // renderer's own start cycle does not count.
    always_comb begin
        advance = 1'b0;
        case (state)
            ST_ABORT: advance = 1'b1;
            ST_L0:    advance = layer0_done && !layer0_start;
            ST_L1:    advance = layer1_done && !layer1_start;
            ST_SPR:   advance = sprite_done && !sprite_start;
            default:  advance = 1'b0;
        endcase
    end

    // Pick the next unit from a fresh request or the held snapshot.
    always_comb begin
        nxt = ST_IDLE;
        if (line_render_start && !busy)
            nxt = next_unit(ST_IDLE, en_in);
        else
            nxt = next_unit(state, en_q);
    end

    // Sequencer: latches the request, issues pulses, runs watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            en_q            <= '0;
            wdog            <= '0;
            render_line_idx <= '0;
            lb_wr_bank      <= 1'b0;
            busy            <= 1'b0;
            layer0_start    <= 1'b0;
            layer1_start    <= 1'b0;
            sprite_start    <= 1'b0;
            render_abort    <= 1'b0;
            line_done       <= 1'b0;
        end else begin
            layer0_start <= 1'b0;
            layer1_start <= 1'b0;
            sprite_start <= 1'b0;
            render_abort <= 1'b0;
            line_done    <= 1'b0;

            if (busy)
                wdog <= wdog + 1'b1;

            if (line_render_start) begin
                render_line_idx <= line_idx;
                en_q            <= en_in;
                lb_wr_bank      <= !lb_wr_bank;
                wdog            <= '0;
            end

            if (overrun_inc) begin
                state        <= ST_ABORT;
                busy         <= 1'b1;
                render_abort <= 1'b1;
            end else if (timeout_inc) begin
                state        <= ST_IDLE;
                busy         <= 1'b0;
                render_abort <= 1'b1;
                wdog         <= '0;
            end else if (line_render_start || advance) begin
                state        <= nxt;
                busy         <= (nxt != ST_IDLE);
                layer0_start <= (nxt == ST_L0);
                layer1_start <= (nxt == ST_L1);
                sprite_start <= (nxt == ST_SPR);
                line_done    <= (nxt == ST_IDLE);
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_overrun_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (overrun_inc),
        .clr   (clear_stats),
        .value (overrun_cnt)
    );

    sat_counter #(.W(CNT_W)) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (timeout_inc),
        .clr   (clear_stats),
        .value (timeout_cnt)
    );

endmodule
